// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing generator with pixel-enable divider
//
// Purpose: divides the system clock into a one-cycle pixel strobe and walks a
// free-running raster, producing coordinates, display-enable, sync levels and
// line/frame start pulses that are always mutually consistent.
//
// Ports:
//   CLK100MHZ    in   system clock
//   CPU_RESETN   in   asynchronous active-low reset
//   pix_en       out  one-cycle strobe, outputs hold a new pixel this cycle
//   hcount       out  horizontal position 0..H_TOTAL-1
//   vcount       out  vertical position 0..V_TOTAL-1
//   de           out  inside the visible area
//   hsync/vsync  out  sync levels, polarity from HS_POL/VS_POL
//   line_start   out  pulse with pix_en when hcount becomes 0
//   frame_start  out  pulse with pix_en when (hcount,vcount) becomes (0,0)
module vga_timing_gen #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int CW       = 10
) (
  input  logic          CLK100MHZ,
  input  logic          CPU_RESETN,
  output logic          pix_en,
  output logic [CW-1:0] hcount,
  output logic [CW-1:0] vcount,
  output logic          de,
  output logic          hsync,
  output logic          vsync,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;
  localparam int DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic HS_ON  = (HS_POL != 0);
  localparam logic VS_ON  = (VS_POL != 0);

  if (CLK_DIV < 1) begin : g_bad_div
    $error("vga_timing_gen: CLK_DIV must be >= 1");
  end
  if ((2 ** CW) < H_TOTAL || (2 ** CW) < V_TOTAL) begin : g_bad_cw
    $error("vga_timing_gen: CW too small for H_TOTAL/V_TOTAL");
  end

  logic [DW-1:0] div_q, div_d;
  logic          tick;
  logic          pix_en_q;
  logic [CW-1:0] hcount_q, vcount_q;
  logic [CW-1:0] h_nxt, v_nxt;
  logic          de_q, hsync_q, vsync_q, line_start_q, frame_start_q;
  logic          de_nxt, hs_nxt, vs_nxt;

  always_comb begin
    tick   = (div_q == DW'(CLK_DIV - 1));
    div_d  = tick ? '0 : div_q + DW'(1);
    h_nxt  = hcount_q + CW'(1);
    v_nxt  = vcount_q;
    if (hcount_q == CW'(H_TOTAL - 1)) begin
      h_nxt = '0;
      v_nxt = (vcount_q == CW'(V_TOTAL - 1)) ? '0 : vcount_q + CW'(1);
    end
    // Decodes look at the position being entered, so every output registered
    // on the same tick describes the same pixel.
    de_nxt = (int'(h_nxt) < H_ACTIVE) && (int'(v_nxt) < V_ACTIVE);
    hs_nxt = (int'(h_nxt) >= HS_START && int'(h_nxt) < HS_END) ? HS_ON : ~HS_ON;
    vs_nxt = (int'(v_nxt) >= VS_START && int'(v_nxt) < VS_END) ? VS_ON : ~VS_ON;
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      div_q         <= '0;
      pix_en_q      <= 1'b0;
      hcount_q      <= CW'(H_TOTAL - 1);
      vcount_q      <= CW'(V_TOTAL - 1);
      de_q          <= 1'b0;
      hsync_q       <= ~HS_ON;
      vsync_q       <= ~VS_ON;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_q    <= div_d;
      pix_en_q <= tick;
      // Pulses are re-evaluated every clock so they last exactly one pix_en cycle.
      line_start_q  <= tick && (h_nxt == '0);
      frame_start_q <= tick && (h_nxt == '0) && (v_nxt == '0);
      if (tick) begin
        hcount_q <= h_nxt;
        vcount_q <= v_nxt;
        de_q     <= de_nxt;
        hsync_q  <= hs_nxt;
        vsync_q  <= vs_nxt;
      end
    end
  end

  assign pix_en      = pix_en_q;
  assign hcount      = hcount_q;
  assign vcount      = vcount_q;
  assign de          = de_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - scoreboard bench for vga_timing_gen
//
// Purpose: three raster configurations share one reset that is released and
// re-asserted at random points; expected pixels come from plain arithmetic
// on the pixel index and are matched against each pix_en strobe.
// Ports: none (top-level bench).
module tb_vga_timing_gen;

  typedef struct {
    int d;
    int ha, hf, hs, hb;
    int va, vf, vs, vb;
    int hp, vp;
  } cfg_t;

  typedef struct {
    int cyc;
    int h, v;
    int flags;  // {de, hsync, vsync, line_start, frame_start}
  } exp_t;

  function automatic cfg_t get_cfg(input int i);
    cfg_t c;
    case (i)
      0:       c = '{4, 640, 16, 96, 48, 480, 10, 2, 33, 0, 0};
      1:       c = '{3, 8, 2, 3, 2, 5, 1, 2, 2, 0, 1};
      default: c = '{1, 8, 1, 2, 1, 4, 1, 1, 1, 1, 0};
    endcase
    return c;
  endfunction

  // The n-th pixel after reset release sits at raster index n.
  function automatic exp_t model(input int i, input int n);
    cfg_t c;
    exp_t e;
    int ht, vt, hsl, vsl, dev, ls, fs;
    c   = get_cfg(i);
    ht  = c.ha + c.hf + c.hs + c.hb;
    vt  = c.va + c.vf + c.vs + c.vb;
    e.cyc = (n + 1) * c.d;
    e.h = n % ht;
    e.v = (n / ht) % vt;
    dev = (e.h < c.ha && e.v < c.va) ? 1 : 0;
    hsl = (e.h >= c.ha + c.hf && e.h < c.ha + c.hf + c.hs) ? c.hp : 1 - c.hp;
    vsl = (e.v >= c.va + c.vf && e.v < c.va + c.vf + c.vs) ? c.vp : 1 - c.vp;
    ls  = (e.h == 0) ? 1 : 0;
    fs  = (e.h == 0 && e.v == 0) ? 1 : 0;
    e.flags = dev * 16 + hsl * 8 + vsl * 4 + ls * 2 + fs;
    return e;
  endfunction

  logic       clk;
  logic       rst_n;
  logic       pe[3];
  logic [9:0] hc[3];
  logic [9:0] vc[3];
  logic       de[3], hs[3], vs[3], ls[3], fs[3];

  int   n_checks;
  int   n_fail;
  exp_t q[3][$];

  vga_timing_gen u_dut0 (
    .CLK100MHZ(clk), .CPU_RESETN(rst_n), .pix_en(pe[0]), .hcount(hc[0]), .vcount(vc[0]),
    .de(de[0]), .hsync(hs[0]), .vsync(vs[0]), .line_start(ls[0]), .frame_start(fs[0])
  );

  vga_timing_gen #(
    .CLK_DIV(3), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(5), .V_FP(1), .V_SYNC(2), .V_BP(2), .HS_POL(0), .VS_POL(1), .CW(10)
  ) u_dut1 (
    .CLK100MHZ(clk), .CPU_RESETN(rst_n), .pix_en(pe[1]), .hcount(hc[1]), .vcount(vc[1]),
    .de(de[1]), .hsync(hs[1]), .vsync(vs[1]), .line_start(ls[1]), .frame_start(fs[1])
  );

  vga_timing_gen #(
    .CLK_DIV(1), .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .HS_POL(1), .VS_POL(0), .CW(10)
  ) u_dut2 (
    .CLK100MHZ(clk), .CPU_RESETN(rst_n), .pix_en(pe[2]), .hcount(hc[2]), .vcount(vc[2]),
    .de(de[2]), .hsync(hs[2]), .vsync(vs[2]), .line_start(ls[2]), .frame_start(fs[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input int inst, input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL dut%0d %s: got %0d, expected %0d at %0t", inst, name, act, exp, $time);
    end
  endtask

  task automatic check_reset_values();
    cfg_t c;
    int   rflags;
    for (int i = 0; i < 3; i++) begin
      c = get_cfg(i);
      rflags = (1 - c.hp) * 8 + (1 - c.vp) * 4;
      chk(i, "reset_pix_en", int'(pe[i]), 0);
      chk(i, "reset_hcount", int'(hc[i]), c.ha + c.hf + c.hs + c.hb - 1);
      chk(i, "reset_vcount", int'(vc[i]), c.va + c.vf + c.vs + c.vb - 1);
      chk(i, "reset_flags", int'({de[i], hs[i], vs[i], ls[i], fs[i]}), rflags);
    end
  endtask

  // Monitors: one per instance, each popping its own expected-pixel queue.
  for (genvar g = 0; g < 3; g++) begin : g_mon
    int   cyc;
    exp_t e;
    always @(posedge clk) begin
      #1;
      if (!rst_n) begin
        cyc = 0;
      end else begin
        cyc++;
        if (pe[g]) begin
          if (q[g].size() == 0) begin
            chk(g, "unexpected_pix_en", 1, 0);
          end else begin
            e = q[g].pop_front();
            chk(g, "pix_cycle", cyc, e.cyc);
            chk(g, "hcount", int'(hc[g]), e.h);
            chk(g, "vcount", int'(vc[g]), e.v);
            chk(g, "flags", int'({de[g], hs[g], vs[g], ls[g], fs[g]}), e.flags);
          end
        end else begin
          chk(g, "pulse_without_pix_en", int'({ls[g], fs[g]}), 0);
        end
      end
    end
  end

  initial begin
    int c_run;
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1 check_reset_values();
    for (int seg = 0; seg < 6; seg++) begin
      // First segment covers one full default line plus the next line start.
      c_run = (seg == 0) ? 3300 : int'($urandom_range(50, 2500));
      for (int i = 0; i < 3; i++) begin
        for (int n = 0; n < c_run / get_cfg(i).d; n++) q[i].push_back(model(i, n));
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (c_run) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_reset_values();
      for (int i = 0; i < 3; i++) begin
        chk(i, "pixels_outstanding", q[i].size(), 0);
        q[i].delete();
      end
      repeat ($urandom_range(1, 4)) @(posedge clk);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
